// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction-side SRAM controller.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        GRANT
    } instr_mem_state_e;

    // Wide enough for WAIT_STATES up to 15.
    localparam int unsigned WAIT_CNT_W = 4;

    // True when addr falls in [base, base + bytes). The subtraction is done in
    // 33 bits so an address below base lands above any legal window size.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [32:0] bytes);
        logic [32:0] offset;
        offset = {1'b0, addr} - {1'b0, base};
        return offset < bytes;
    endfunction

endpackage

// File: rtl/instr_mem_ctrl.sv
// Terminates the instruction req/gnt/rvalid handshake on a 1-cycle-latency
// synchronous SRAM, with programmable grant wait states and error responses
// for out-of-range or misaligned addresses. At most one response is in flight.
module instr_mem_ctrl
    import instr_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned NUM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned MEM_AW      = $clog2(NUM_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              instr_req_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    input  logic [31:0]       instr_addr_i,
    output logic [31:0]       instr_rdata_o,
    output logic              instr_err_o,

    output logic              mem_en_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam logic [32:0]           WINDOW_BYTES = 33'(NUM_WORDS) << 2;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD    = WAIT_CNT_W'(WAIT_STATES - 1);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE      = WAIT_CNT_W'(1);

    instr_mem_state_e        state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    pend_q, bad_q;

    logic                    bad;
    logic                    fsm_gnt;
    logic                    transfer;
    logic [MEM_AW+1:0]       offset_lo;
    logic                    unused_offset_lsb;

    // Address decode: window and alignment check, byte offset into the SRAM.
    always_comb begin
        bad       = !in_window(instr_addr_i, BASE_ADDR, WINDOW_BYTES) ||
                    (instr_addr_i[1:0] != 2'b00);
        offset_lo = instr_addr_i[MEM_AW+1:0] - BASE_ADDR[MEM_AW+1:0];
    end

    // Offset byte lanes are irrelevant once alignment has been checked.
    assign unused_offset_lsb = ^offset_lo[1:0];

    // Grant FSM next state. The counter is loaded with WAIT_STATES-1 and the
    // move to GRANT happens as it steps to zero, so gnt rises exactly
    // WAIT_STATES cycles after req.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fsm_gnt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (instr_req_i) begin
                    if (WAIT_STATES == 0) begin
                        fsm_gnt = 1'b1;
                    end else if (WAIT_STATES == 1) begin
                        state_d = GRANT;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!instr_req_i) begin
                    // Request withdrawn: abandon silently.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = GRANT;
                        cnt_d   = '0;
                    end
                end
            end
            GRANT: begin
                fsm_gnt = instr_req_i;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake outputs. Everything is masked while reset is asserted so a
    // response due in a reset cycle is dropped.
    always_comb begin
        instr_gnt_o    = fsm_gnt && !rst_i;
        transfer       = instr_req_i && instr_gnt_o;
        mem_en_o       = transfer && !bad;
        mem_addr_o     = mem_en_o ? offset_lo[MEM_AW+1:2] : '0;
        instr_rvalid_o = pend_q && !rst_i;
        instr_err_o    = instr_rvalid_o && bad_q;
        // SRAM data is passed through only for a live, good response.
        instr_rdata_o  = (instr_rvalid_o && !bad_q) ? mem_rdata_i : '0;
    end

    // State, wait counter and pending-response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= transfer;
            bad_q   <= transfer && bad;
        end
    end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Self-checking bench: four controller instances (different wait states and
// base addresses) run directed scenarios, then randomized traffic, all
// checked every cycle against a cycle-count reference model.
module tb_instr_mem_ctrl;

    localparam int NUM_DUT = 4;
    localparam int unsigned WS_TAB [NUM_DUT] = '{0, 3, 2, 0};
    localparam logic [31:0] BASE_TAB [NUM_DUT] = '{32'h0, 32'h0, 32'h0, 32'h0001_0000};

    logic        clk = 1'b0;
    logic        rst;
    logic        req       [NUM_DUT];
    logic [31:0] addr      [NUM_DUT];
    logic        gnt       [NUM_DUT];
    logic        rvalid    [NUM_DUT];
    logic [31:0] rdata     [NUM_DUT];
    logic        err       [NUM_DUT];
    logic        mem_en    [NUM_DUT];
    logic [9:0]  mem_addr  [NUM_DUT];
    logic [31:0] mem_rdata [NUM_DUT];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NUM_DUT; k++) begin : g_dut
        instr_mem_ctrl #(
            .BASE_ADDR  (BASE_TAB[k]),
            .NUM_WORDS  (1024),
            .WAIT_STATES(WS_TAB[k])
        ) u_dut (
            .clk_i         (clk),
            .rst_i         (rst),
            .instr_req_i   (req[k]),
            .instr_gnt_o   (gnt[k]),
            .instr_rvalid_o(rvalid[k]),
            .instr_addr_i  (addr[k]),
            .instr_rdata_o (rdata[k]),
            .instr_err_o   (err[k]),
            .mem_en_o      (mem_en[k]),
            .mem_addr_o    (mem_addr[k]),
            .mem_rdata_i   (mem_rdata[k])
        );
    end

    // SRAM model: word[i] = i * 0x11111111; garbage when not enabled.
    always @(posedge clk) begin
        for (int k = 0; k < NUM_DUT; k++) begin
            if (mem_en[k]) mem_rdata[k] <= {22'b0, mem_addr[k]} * 32'h1111_1111;
            else           mem_rdata[k] <= $urandom;
        end
    end

    int ntests = 0;
    int nfail  = 0;

    // Reference model state.
    int          run       [NUM_DUT];  // consecutive req-high cycles in this attempt
    bit          pend      [NUM_DUT];
    bit          pend_bad  [NUM_DUT];
    logic [31:0] pend_word [NUM_DUT];
    bit          e_gnt     [NUM_DUT];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_bad(input int k, input logic [31:0] a);
        longint la = {32'h0, a};
        longint lb = {32'h0, BASE_TAB[k]};
        return (a % 4 != 0) || (la < lb) || (la >= lb + 4 * 1024);
    endfunction

    function automatic logic [31:0] word_idx(input int k, input logic [31:0] a);
        return (a - BASE_TAB[k]) / 4;
    endfunction

    // Compare all DUT outputs against the model in the current cycle.
    task automatic sample();
        @(negedge clk);
        for (int k = 0; k < NUM_DUT; k++) begin
            bit tr, bd, rv;
            bd = is_bad(k, addr[k]);
            tr = !rst && req[k] && (run[k] == int'(WS_TAB[k]));
            rv = !rst && pend[k];
            e_gnt[k] = tr;
            chk($sformatf("d%0d gnt", k), 32'(gnt[k]), 32'(tr));
            chk($sformatf("d%0d mem_en", k), 32'(mem_en[k]), 32'(tr && !bd));
            chk($sformatf("d%0d mem_addr", k), 32'(mem_addr[k]),
                (tr && !bd) ? word_idx(k, addr[k]) : 32'h0);
            chk($sformatf("d%0d rvalid", k), 32'(rvalid[k]), 32'(rv));
            chk($sformatf("d%0d err", k), 32'(err[k]), 32'(rv && pend_bad[k]));
            chk($sformatf("d%0d rdata", k), rdata[k],
                (rv && !pend_bad[k]) ? pend_word[k] : 32'h0);
        end
    endtask

    // Update the model for the clock edge and move to the next cycle.
    task automatic advance();
        for (int k = 0; k < NUM_DUT; k++) begin
            if (rst) begin
                run[k]  = 0;
                pend[k] = 1'b0;
            end else begin
                pend[k]      = e_gnt[k];
                pend_bad[k]  = is_bad(k, addr[k]);
                pend_word[k] = word_idx(k, addr[k]) * 32'h1111_1111;
                if (!req[k] || e_gnt[k]) run[k] = 0;
                else                     run[k]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr(input int k);
        logic [31:0] b = BASE_TAB[k];
        case ($urandom_range(0, 4))
            0:       return b + 4 * $urandom_range(0, 1023);
            1:       return b + $urandom_range(0, 4095);
            2:       return $urandom;
            3:       return b + 4096 - 4 * $urandom_range(0, 1);
            default: return b - 4 * $urandom_range(0, 1);
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        for (int k = 0; k < NUM_DUT; k++) begin
            req[k] = 1'b0; addr[k] = 32'h0; run[k] = 0;
            pend[k] = 1'b0; pend_bad[k] = 1'b0; pend_word[k] = 32'h0; e_gnt[k] = 1'b0;
        end
        req[0] = 1'b1;  // request during reset must not be granted

        // Reset
        sample(); chk("rst gnt", 32'(gnt[0]), 32'h0); advance();
        sample(); chk("rst rvalid", 32'(rvalid[0]), 32'h0); advance();
        rst = 1'b0;

        // Zero wait states: three back-to-back reads
        addr[0] = 32'h0; sample(); chk("ws0 gnt0", 32'(gnt[0]), 32'h1); advance();
        addr[0] = 32'h4; sample(); chk("ws0 rdata0", rdata[0], 32'h0);
        chk("ws0 rvalid0", 32'(rvalid[0]), 32'h1); advance();
        addr[0] = 32'h8; sample(); chk("ws0 rdata1", rdata[0], 32'h1111_1111); advance();
        req[0] = 1'b0; sample(); chk("ws0 rdata2", rdata[0], 32'h2222_2222);
        chk("ws0 err2", 32'(err[0]), 32'h0); advance();
        sample(); chk("ws0 idle rvalid", 32'(rvalid[0]), 32'h0); advance();

        // Three wait states, request held
        req[1] = 1'b1; addr[1] = 32'h10;
        for (int i = 0; i < 3; i++) begin
            sample(); chk("ws3 early gnt", 32'(gnt[1]), 32'h0);
            chk("ws3 early mem_en", 32'(mem_en[1]), 32'h0); advance();
        end
        sample(); chk("ws3 gnt", 32'(gnt[1]), 32'h1);
        chk("ws3 mem_addr", 32'(mem_addr[1]), 32'h4); advance();
        req[1] = 1'b0; sample(); chk("ws3 rdata", rdata[1], 32'h4444_4444); advance();

        // Out-of-range and misaligned accesses
        req[0] = 1'b1; addr[0] = 32'h0000_1000;
        sample(); chk("oor gnt", 32'(gnt[0]), 32'h1); chk("oor mem_en", 32'(mem_en[0]), 32'h0);
        advance();
        addr[0] = 32'h6; sample(); chk("oor err", 32'(err[0]), 32'h1);
        chk("mis mem_en", 32'(mem_en[0]), 32'h0); advance();
        req[0] = 1'b0; sample(); chk("mis err", 32'(err[0]), 32'h1);
        chk("mis rdata", rdata[0], 32'h0); advance();

        // Two wait states: abandoned request, grant, then reset on the response
        req[2] = 1'b1; addr[2] = 32'h20; sample(); advance();
        req[2] = 1'b0; sample(); advance();
        sample(); advance();
        req[2] = 1'b1; addr[2] = 32'h24;
        for (int i = 0; i < 2; i++) begin
            sample(); chk("ws2 no gnt", 32'(gnt[2]), 32'h0);
            chk("ws2 no rvalid", 32'(rvalid[2]), 32'h0); advance();
        end
        addr[2] = 32'h28; sample(); chk("ws2 gnt", 32'(gnt[2]), 32'h1);
        chk("ws2 mem_addr", 32'(mem_addr[2]), 32'd10); advance();
        req[2] = 1'b0; rst = 1'b1; sample(); chk("rst drop rvalid", 32'(rvalid[2]), 32'h0); advance();
        rst = 1'b0; sample(); chk("post rst rvalid", 32'(rvalid[2]), 32'h0);
        chk("post rst rdata", rdata[2], 32'h0); advance();
        req[2] = 1'b1; addr[2] = 32'h20; sample(); advance(); sample(); advance();
        sample(); chk("ws2 regnt", 32'(gnt[2]), 32'h1); advance();
        req[2] = 1'b0; sample(); chk("ws2 rerdata", rdata[2], 32'h8888_8888); advance();

        // Non-zero base address boundaries
        req[3] = 1'b1; addr[3] = 32'h0000_FFFC;
        sample(); chk("base below mem_en", 32'(mem_en[3]), 32'h0); advance();
        addr[3] = 32'h0001_0FFC; sample(); chk("base below err", 32'(err[3]), 32'h1);
        chk("base top mem_addr", 32'(mem_addr[3]), 32'd1023); advance();
        req[3] = 1'b0; sample(); chk("base top err", 32'(err[3]), 32'h0);
        chk("base top rdata", rdata[3], 32'h3333_32EF); advance();

        // Randomized traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            for (int k = 0; k < NUM_DUT; k++) begin
                req[k]  = ($urandom_range(0, 9) < 7);
                addr[k] = rand_addr(k);
            end
            sample(); advance();
        end
        rst = 1'b0;
        for (int k = 0; k < NUM_DUT; k++) req[k] = 1'b0;
        sample(); advance();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
